// File: rtl/r2b_pkg.sv
// Shared types, default sizes and derived-size helpers for the row-to-block converter.
package r2b_pkg;

  localparam int unsigned WIDTH_DEF      = 16;
  localparam int unsigned FRAC_WIDTH_DEF = 8;
  localparam int unsigned ROW_DEF        = 8;
  localparam int unsigned COL_DEF        = 6;
  localparam int unsigned BLOCK_SIZE_DEF = 2;
  localparam int unsigned CHUNK_SIZE_DEF = 4;
  localparam int unsigned NUM_CORES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } r2b_state_e;

  // Rows that make up one band (one row of blocks per core).
  function automatic int unsigned band_rows(input int unsigned block_size,
                                            input int unsigned num_cores);
    return block_size * num_cores;
  endfunction

  // Number of bands in the matrix.
  function automatic int unsigned num_bands(input int unsigned row,
                                            input int unsigned block_size,
                                            input int unsigned num_cores);
    return row / (block_size * num_cores);
  endfunction

  // Block columns, i.e. words emitted per band.
  function automatic int unsigned bcols(input int unsigned col,
                                        input int unsigned block_size);
    return col / block_size;
  endfunction

  // Counter width able to index n entries (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/r2b_band_buffer.sv
// One band of rows, written a row at a time and read back as a block word per block column.
module r2b_band_buffer
  import r2b_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned COL        = COL_DEF,
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
  localparam int unsigned BAND_ROWS = band_rows(BLOCK_SIZE, NUM_CORES),
  localparam int unsigned CHUNK     = BLOCK_SIZE * BLOCK_SIZE,
  localparam int unsigned ROW_W     = WIDTH * COL,
  localparam int unsigned OUT_W     = WIDTH * CHUNK * NUM_CORES,
  localparam int unsigned RW        = cnt_width(BAND_ROWS),
  localparam int unsigned BCW       = cnt_width(bcols(COL, BLOCK_SIZE))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [RW-1:0]    wr_row_i,
  input  logic [ROW_W-1:0] wr_data_i,
  input  logic [BCW-1:0]   bc_i,
  output logic [OUT_W-1:0] rd_data_c_o
);

  logic [ROW_W-1:0] mem_q    [BAND_ROWS];
  logic [ROW_W-1:0] row_view [BAND_ROWS];

  // Row storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < BAND_ROWS; r++) mem_q[r] <= '0;
    end else if (we_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  // Write-through view so the band's last row is visible in the cycle it is written.
  always_comb begin
    for (int r = 0; r < BAND_ROWS; r++) row_view[r] = mem_q[r];
    if (we_i) row_view[wr_row_i] = wr_data_i;
  end

  // Gather block column bc: core c takes rows c*BLOCK_SIZE.., element (r,k) at r*BLOCK_SIZE+k.
  always_comb begin
    rd_data_c_o = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int r = 0; r < BLOCK_SIZE; r++) begin
        for (int k = 0; k < BLOCK_SIZE; k++) begin
          rd_data_c_o[(c*CHUNK + r*BLOCK_SIZE + k)*WIDTH +: WIDTH] =
            row_view[c*BLOCK_SIZE + r][(int'(bc_i)*BLOCK_SIZE + k)*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/r2b_converter.sv
// Row-to-block converter: buffers a band of rows, then emits one block word per block column.
// Optional R2B_PINGPONG_EN: two band buffers so the next band fills while the current one drains.
module r2b_converter
  import r2b_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int unsigned ROW        = ROW_DEF,
  parameter int unsigned COL        = COL_DEF,
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int unsigned CHUNK_SIZE = CHUNK_SIZE_DEF,
  parameter int unsigned NUM_CORES  = NUM_CORES_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH*COL-1:0]                 in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_data,
  output logic                                 done
);

  localparam int unsigned BAND_ROWS = band_rows(BLOCK_SIZE, NUM_CORES);
  localparam int unsigned NUM_BANDS = num_bands(ROW, BLOCK_SIZE, NUM_CORES);
  localparam int unsigned BCOLS     = bcols(COL, BLOCK_SIZE);
  localparam int unsigned OUT_W     = WIDTH * CHUNK_SIZE * NUM_CORES;
  localparam int unsigned RW        = cnt_width(BAND_ROWS);
  localparam int unsigned BCW       = cnt_width(BCOLS);
  localparam int unsigned BKW       = cnt_width(NUM_BANDS);
  localparam int unsigned BNW       = cnt_width(NUM_BANDS + 1);

`ifdef R2B_PINGPONG_EN
  localparam int unsigned NBUF = 2;
  localparam bit          PP   = 1'b1;
`else
  localparam int unsigned NBUF = 1;
  localparam bit          PP   = 1'b0;
`endif

  // Elaboration-time sanity of the geometry.
  if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_bad_chunk
    $error("r2b_converter: CHUNK_SIZE must equal BLOCK_SIZE squared");
  end
  if ((ROW % BAND_ROWS) != 0 || (COL % BLOCK_SIZE) != 0) begin : g_bad_dims
    $error("r2b_converter: ROW/COL not multiples of the band/block size");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("r2b_converter: FRAC_WIDTH exceeds WIDTH");
  end

  r2b_state_e       state_q, state_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic [BNW-1:0]   bands_in_q, bands_in_d;
  logic [BKW-1:0]   band_cnt_q, band_cnt_d;
  logic [BCW-1:0]   bc_cnt_q, bc_cnt_d;
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             fill_side;

  logic             wr_en;
  logic [BCW-1:0]   bc_nxt;
  logic [OUT_W-1:0] gather_c [NBUF];
  logic [OUT_W-1:0] rd_gather_c;

  assign wr_en = in_valid && in_ready_q;

  // Block column of the next word to load: successor while draining, else column 0.
  assign bc_nxt = (state_q == DRAIN && bc_cnt_q != BCW'(BCOLS - 1)) ? bc_cnt_q + BCW'(1) : '0;

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    r2b_band_buffer #(
      .WIDTH      (WIDTH),
      .COL        (COL),
      .BLOCK_SIZE (BLOCK_SIZE),
      .NUM_CORES  (NUM_CORES)
    ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .we_i        (wr_en && (wr_sel_q == 1'(b))),
      .wr_row_i    (row_cnt_q),
      .wr_data_i   (in_data),
      .bc_i        (bc_nxt),
      .rd_data_c_o (gather_c[b])
    );
  end

`ifdef R2B_PINGPONG_EN
  assign rd_gather_c = rd_sel_q ? gather_c[1] : gather_c[0];
`else
  assign rd_gather_c = gather_c[0];
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      bands_in_q  <= '0;
      band_cnt_q  <= '0;
      bc_cnt_q    <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      bands_in_q  <= bands_in_d;
      band_cnt_q  <= band_cnt_d;
      bc_cnt_q    <= bc_cnt_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Fill bookkeeping, drain sequencing and next-cycle outputs.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    bands_in_d  = bands_in_q;
    band_cnt_d  = band_cnt_q;
    bc_cnt_d    = bc_cnt_q;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    in_ready_d  = 1'b0;
    fill_side   = 1'b0;

    if (wr_en) begin
      if (row_cnt_q == RW'(BAND_ROWS - 1)) begin
        row_cnt_d        = '0;
        full_d[wr_sel_q] = 1'b1;
        bands_in_d       = bands_in_q + BNW'(1);
        if (PP) wr_sel_d = ~wr_sel_q;
      end else begin
        row_cnt_d = row_cnt_q + RW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          row_cnt_d  = '0;
          bands_in_d = '0;
          band_cnt_d = '0;
          bc_cnt_d   = '0;
          full_d     = '0;
          wr_sel_d   = 1'b0;
          rd_sel_d   = 1'b0;
        end
      end
      FILL: begin
        if (full_d[rd_sel_q]) begin
          state_d     = DRAIN;
          bc_cnt_d    = '0;
          out_valid_d = 1'b1;
          out_data_d  = rd_gather_c;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (bc_cnt_q == BCW'(BCOLS - 1)) begin
            out_valid_d      = 1'b0;
            bc_cnt_d         = '0;
            full_d[rd_sel_q] = 1'b0;
            if (PP) rd_sel_d = ~rd_sel_q;
            if (band_cnt_q == BKW'(NUM_BANDS - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              band_cnt_d = band_cnt_q + BKW'(1);
              state_d    = FILL;
            end
          end else begin
            bc_cnt_d   = bc_cnt_q + BCW'(1);
            out_data_d = rd_gather_c;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fill_side  = (state_d == FILL) || (PP && (state_d == DRAIN));
    in_ready_d = fill_side && !full_d[wr_sel_d] && (bands_in_d < BNW'(NUM_BANDS));
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_r2b_converter.sv
// Scoreboard bench for r2b_converter at default parameters.
module tb_r2b_converter;

  localparam int WIDTH  = 16;
  localparam int ROW    = 8;
  localparam int COL    = 6;
  localparam int BS     = 2;
  localparam int CHUNK  = 4;
  localparam int NC     = 2;
  localparam int BAND   = BS * NC;
  localparam int NBANDS = ROW / BAND;
  localparam int BCOLS  = COL / BS;
  localparam int NWORDS = NBANDS * BCOLS;
  localparam int OW     = WIDTH * CHUNK * NC;
  localparam int RW     = WIDTH * COL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          done;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int start_cyc = 0;
  bit toggle_ready = 1'b0;

  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] got_q [$];

  r2b_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [WIDTH-1:0] elem(input int r, input int j);
    return WIDTH'((r * COL + j) << 8);
  endfunction

  function automatic logic [RW-1:0] row_word(input int r);
    logic [RW-1:0] w;
    w = '0;
    for (int j = 0; j < COL; j++) w[j*WIDTH +: WIDTH] = elem(r, j);
    return w;
  endfunction

  function automatic logic [OW-1:0] exp_word(input int b, input int bc);
    logic [OW-1:0] w;
    w = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < BS; r++)
        for (int k = 0; k < BS; k++)
          w[(c*CHUNK + r*BS + k)*WIDTH +: WIDTH] = elem(b*BAND + c*BS + r, bc*BS + k);
    return w;
  endfunction

  // Output driver: ready held high, or toggled every cycle when requested.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) out_ready = ~out_ready;
      else              out_ready = 1'b1;
    end
  end

  // Monitor: compare every presented word to the scoreboard head, pop on acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", out_data, '0);
        end else begin
          check("word", out_data, exp_q[0]);
          if (out_ready) begin
            got_q.push_back(out_data);
            exp_q.delete(0);
          end
        end
`ifndef R2B_PINGPONG_EN
        check("in_ready_in_drain", in_ready, 1'b0);
`endif
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic drive_rows(input int gap, input int nrows, input bit mid_start);
    for (int r = 0; r < nrows; r++) begin
      bit acc;
      int guard;
      acc      = 1'b0;
      guard    = 0;
      in_data  = row_word(r);
      in_valid = 1'b1;
      while (!acc && guard < 500) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard++;
      end
      if (!acc) check("row_accept_timeout", 0, 1);
      in_valid = 1'b0;
      if (mid_start && r == 1) start = 1'b1;
      repeat (gap) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic run_matrix(input int gap, input bit mid_start, input bit toggle, input string tag);
    int guard;
    got_q.delete();
    done_cnt     = 0;
    toggle_ready = toggle;
    for (int b = 0; b < NBANDS; b++)
      for (int bc = 0; bc < BCOLS; bc++) exp_q.push_back(exp_word(b, bc));
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_rows(gap, ROW, mid_start);
    guard = 0;
    while (done_cnt == 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_word_count"}, got_q.size(), NWORDS);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    toggle_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] w;
    logic [RW-1:0] rec;
    logic [OW-1:0] lit;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // in_valid in IDLE must not be accepted.
    in_data  = row_word(7);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Full matrix, ready held high.
    run_matrix(0, 1'b0, 1'b0, "full");
`ifndef R2B_PINGPONG_EN
    check("full_latency", done_cyc - start_cyc, ROW + NWORDS + 1);
`endif
    lit = {16'h1300, 16'h1200, 16'h0D00, 16'h0C00, 16'h0700, 16'h0600, 16'h0100, 16'h0000};
    w = (got_q.size() > 0) ? got_q[0] : '0;
    check("full_word0", w, lit);
    lit = {16'h2F00, 16'h2E00, 16'h2900, 16'h2800, 16'h2300, 16'h2200, 16'h1D00, 16'h1C00};
    w = (got_q.size() > 5) ? got_q[5] : '0;
    check("full_word5", w, lit);

    // Inverse mapping back to rows.
    for (int r = 0; r < ROW; r++) begin
      int b;
      int c;
      int rr;
      b   = r / BAND;
      c   = (r % BAND) / BS;
      rr  = r % BS;
      rec = '0;
      for (int bc = 0; bc < BCOLS; bc++) begin
        w = (got_q.size() > b*BCOLS + bc) ? got_q[b*BCOLS + bc] : '0;
        for (int k = 0; k < BS; k++)
          rec[(bc*BS + k)*WIDTH +: WIDTH] = w[(c*CHUNK + rr*BS + k)*WIDTH +: WIDTH];
      end
      check($sformatf("loopback_row%0d", r), rec, row_word(r));
    end

    run_matrix(0, 1'b0, 1'b1, "stall");
    run_matrix(3, 1'b0, 1'b0, "gaps");
    run_matrix(0, 1'b1, 1'b0, "start_mid");

    // Abort after three rows.
    done_cnt = 0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_rows(0, 3, 1'b0);
    @(negedge clk);
    check("abort_pre_in_ready", in_ready, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_data", out_data, '0);
    check("abort_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_in_ready_idle", in_ready, 1'b0);
    run_matrix(0, 1'b0, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/r2b_converter.md
# r2b_converter

Row-to-block converter. Accepts a ROW×COL fixed-point matrix one row per beat in row-major order. Re-emits it as block-chunked words: each word carries NUM_CORES square blocks of BLOCK_SIZE×BLOCK_SIZE elements, one block per core. It sits upstream of the multi-MAC core array and is the exact inverse of `b2r_converter`: an `r2b_converter` output fed straight into `b2r_converter` must reproduce the original rows.

## Interface
Parameters:
- WIDTH, 16, element width in bits (Q8.8 by default).
- FRAC_WIDTH, 8, fractional bits. Pass-through only; no arithmetic is done on data.
- ROW, 8, matrix rows. Must be a multiple of BLOCK_SIZE*NUM_CORES.
- COL, 6, matrix columns. Must be a multiple of BLOCK_SIZE.
- BLOCK_SIZE, 2, block edge length.
- CHUNK_SIZE, 4, elements per block. Must equal BLOCK_SIZE².
- NUM_CORES, 2, blocks per output word.

Ports:
- clk, in, 1, single clock. All logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a matrix. Honoured only in IDLE.
- in_valid, in, 1, in_data holds a row.
- in_ready, out, 1, the converter accepts a row this cycle.
- in_data, in, WIDTH*COL, one row. Element j is at bits [j*WIDTH +: WIDTH].
- out_valid, out, 1, out_data holds a block word.
- out_ready, in, 1, the consumer accepts the word.
- out_data, out, WIDTH*CHUNK_SIZE*NUM_CORES, one block word. Core c's chunk is at bits [c*CHUNK_SIZE*WIDTH +: CHUNK_SIZE*WIDTH]. Within a chunk, element (r,k) of the block is at index r*BLOCK_SIZE+k, counting from the LSB.
- done, out, 1, one-cycle pulse after the last word of the matrix is accepted.

## Operation
Derived values:
- BAND_ROWS = BLOCK_SIZE*NUM_CORES
- NUM_BANDS = ROW/BAND_ROWS
- BCOLS = COL/BLOCK_SIZE

Word mapping:
- The matrix is handled band by band. A band is BAND_ROWS consecutive rows.
- Band b emits BCOLS words, with bc running from 0 to BCOLS-1.
- Core c of word (b, bc) carries rows b*BAND_ROWS + c*BLOCK_SIZE + r and columns bc*BLOCK_SIZE + k, for r,k in 0..BLOCK_SIZE-1.

Handshakes:
- Input: a transfer occurs on in_valid && in_ready.
- Output: a transfer occurs on out_valid && out_ready.
- out_valid/out_data stay stable until accepted.

State machine:
- IDLE: in_ready=0. start → FILL, clearing all counters.
- FILL: in_ready=1. Each accepted row is written to the band buffer at row_cnt. On acceptance of row BAND_ROWS-1 → DRAIN.
- DRAIN: words are emitted with bc_cnt running 0..BCOLS-1. On acceptance of the last word:
  - if band_cnt < NUM_BANDS-1, increment band_cnt → FILL;
  - otherwise → DONE.
- DONE: done=1 for exactly one cycle → IDLE.

Boundary rules:
- start outside IDLE is ignored.
- in_valid outside FILL is ignored; no data is captured.
- rst_n asserted mid-matrix aborts immediately. All state returns to IDLE, partial data is discarded, and no done pulse is produced.
- Reset values: in_ready=0, out_valid=0, out_data=0, done=0, all counters 0, state IDLE.

## Timing
- Fill to first output: the first out_valid is in cycle N+1, where N is the cycle in which the band's last row was accepted.
- Drain throughput: with out_ready held high, one word per cycle. Each following word is presented in the cycle after the previous one is accepted.
- After drain, non-last band: in_ready rises in the cycle after the last word is accepted.
- After drain, last band: done pulses in that cycle instead.
- Minimum matrix time without the ping-pong option: ROW + NUM_BANDS*BCOLS + 1 cycles after start, plus 1 for the start cycle.

## Configuration
- R2B_PINGPONG_EN defined:
  - Two band buffers. Band b+1 fills while band b drains.
  - in_ready is high whenever the write buffer is free, including during DRAIN.
  - Output order and timing per band are unchanged.
  - done still follows the final word.
- R2B_PINGPONG_EN undefined: a single band buffer, and in_ready=0 during DRAIN.

## Structure
- Shared package `r2b_pkg` holds:
  - derived-size functions: BAND_ROWS, NUM_BANDS, BCOLS;
  - the state enum: IDLE/FILL/DRAIN/DONE;
  - the width localparams.
- One sub-module, `r2b_band_buffer`:
  - BAND_ROWS×COL register array;
  - row-wide write port;
  - combinational block-gather read indexed by bc.
- The top-level instantiates it once, or twice under R2B_PINGPONG_EN.

## Test plan
Default parameters. Row r element j is fed as (r*COL+j)<<8.

- Full matrix, out_ready=1 → 6 words:
  - word 0: core0 = 0000,0100,0600,0700 and core1 = 0C00,0D00,1200,1300 (element 0 at LSB);
  - word 5: core0 = 1C00,1D00,2200,2300 and core1 = 2800,2900,2E00,2F00;
  - done pulses once.
- out_ready toggling 1/0 every cycle → identical word sequence, with out_data stable during every stall.
- in_valid gaps of 3 cycles between rows → same output; in_ready=0 during DRAIN (ping-pong disabled).
- start pulsed during FILL → ignored, and the word count remains 6.
- rst_n low after 3 rows → outputs reset at once. A new start then yields a correct full matrix.
- Loopback into b2r_converter → each emitted row equals the input row.
